// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [8:0]  RESET_PC    = 9'd0,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter logic [6:0]  HALT_OPCODE = 7'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [8:0]  branch_target_i,
    output logic [8:0]  imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [41:0] if_id_o,
    output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [8:0]  pc_q, pc_d;
    logic [8:0]  id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_halt_q, id_halt_d;
    logic        is_halt;
    logic        fetch_en;

    assign is_halt = (imem_data_i[6:0] == HALT_OPCODE);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_halt_d  = id_halt_q;
        fetch_en   = 1'b0;
        case (state_q)
            StRun: begin
                if (flush_i) begin
                    pc_d       = branch_target_i;
                    id_pc_d    = 9'd0;
                    id_instr_d = NOP_INSTR;
                    id_halt_d  = 1'b0;
                end else if (!stall_i) begin
                    fetch_en   = 1'b1;
                    id_pc_d    = pc_q;
                    id_instr_d = imem_data_i;
                    id_halt_d  = is_halt;
                    if (is_halt) begin
                        state_d = StHalted;
                    end else begin
                        pc_d = pc_q + 9'd4;
                    end
                end
            end
            StHalted: begin
                // A flush here means the halt was on a mispredicted path.
                if (flush_i) begin
                    pc_d       = branch_target_i;
                    id_pc_d    = 9'd0;
                    id_instr_d = NOP_INSTR;
                    id_halt_d  = 1'b0;
                    state_d    = StRun;
                end else if (!stall_i) begin
                    id_pc_d    = 9'd0;
                    id_instr_d = NOP_INSTR;
                    id_halt_d  = 1'b0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            id_pc_q    <= 9'd0;
            id_instr_q <= NOP_INSTR;
            id_halt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_halt_q  <= id_halt_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign if_id_o     = {id_pc_q, id_instr_q, id_halt_q};
    assign halted_o    = (state_q == StHalted);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (fetch_en) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (flush_i) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    logic unused_fetch_en;
    assign unused_fetch_en = fetch_en;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/flush/halt
// traffic compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic [8:0]  tgt;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [41:0] if_id;
    logic        halted;
    logic [8:0]  waddr;
    logic [41:0] wif_id;
    logic        whalted;
    logic [31:0] mem [128];
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt, wfetch_cnt, wflush_cnt;
`endif

    always #5 clk = ~clk;

    assign data = mem[addr[8:2]];

    fetch_stage u_dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (tgt),
        .imem_addr_o     (addr),
        .imem_data_i     (data),
        .if_id_o         (if_id),
        .halted_o        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    // Second instance checks PC wrap from a high reset address.
    fetch_stage #(.RESET_PC(9'd504)) u_wrap (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (1'b0),
        .flush_i         (1'b0),
        .branch_target_i (9'd0),
        .imem_addr_o     (waddr),
        .imem_data_i     (32'h0000_0013),
        .if_id_o         (wif_id),
        .halted_o        (whalted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o     (wfetch_cnt),
        .flush_cnt_o     (wflush_cnt)
`endif
    );

    localparam logic [41:0] Bubble = {9'd0, 32'h0000_0013, 1'b0};

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Behavioural model state
    logic [8:0]  m_pc;
    logic [8:0]  m_ipc;
    logic [31:0] m_instr;
    logic        m_hlt;
    logic        m_halted;
    int unsigned m_fetch, m_flush;
    int unsigned w_k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 9'd0;
        m_ipc    = 9'd0;
        m_instr  = 32'h0000_0013;
        m_hlt    = 1'b0;
        m_halted = 1'b0;
        m_fetch  = 0;
        m_flush  = 0;
        w_k      = 0;
    endtask

    task automatic model_bubble();
        m_ipc   = 9'd0;
        m_instr = 32'h0000_0013;
        m_hlt   = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic f, input logic [8:0] t);
        logic [31:0] word;
        word = mem[m_pc / 4 % 128];
        if (f) begin
            m_pc     = t;
            m_halted = 1'b0;
            m_flush++;
            model_bubble();
        end else if (m_halted) begin
            if (!s) model_bubble();
        end else if (!s) begin
            m_ipc   = m_pc;
            m_instr = word;
            m_hlt   = (word % 128 == 127);
            m_fetch++;
            if (m_hlt) m_halted = 1'b1;
            else m_pc = 9'((int'(m_pc) + 4) % 512);
        end
    endtask

    task automatic check_all();
        check("imem_addr", 64'(addr), 64'(m_pc));
        check("if_id", 64'(if_id), 64'({m_ipc, m_instr, m_hlt}));
        check("halted", 64'(halted), 64'(m_halted));
        check("wrap_addr", 64'(waddr), 64'((504 + 4 * w_k) % 512));
        check("wrap_halt", 64'({whalted, wif_id[0]}), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    task automatic cycle(input logic s, input logic f, input logic [8:0] t);
        stall_i = s;
        flush_i = f;
        tgt     = t;
        @(posedge clk);
        model_step(s, f, t);
        w_k++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        tgt     = 9'd0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();
    endtask

    task automatic fill_addi();
        for (int i = 0; i < 128; i++) begin
            mem[i] = {12'(i), 5'd0, 3'b000, 5'd1, 7'h13};
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [41:0] held;
        fill_addi();
        do_reset();

        // Reset then run
        cycle(1'b0, 1'b0, 9'd0);
        cycle(1'b0, 1'b0, 9'd0);
        check("run_pc8", 64'(addr), 64'd8);
        check("run_lag", 64'(if_id[41:33]), 64'd4);

        // Stall for 3 cycles at PC=8
        held = if_id;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 9'd0);
            check("stall_addr", 64'(addr), 64'd8);
            check("stall_ifid", 64'(if_id), 64'(held));
        end
        cycle(1'b0, 1'b0, 9'd0);
        check("stall_release", 64'(addr), 64'd12);

        // Flush with stall
        cycle(1'b1, 1'b1, 9'd100);
        check("flush_addr", 64'(addr), 64'd100);
        check("flush_bubble", 64'(if_id), 64'(Bubble));
        cycle(1'b0, 1'b0, 9'd0);
        check("flush_pc", 64'(if_id[41:33]), 64'd100);

        // Halt at address 16
        mem[4] = 32'h1234_567F;
        cycle(1'b0, 1'b1, 9'd16);
        cycle(1'b0, 1'b0, 9'd0);
        check("halt_ifid", 64'(if_id), 64'({9'd16, 32'h1234_567F, 1'b1}));
        check("halt_flag", 64'(halted), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 9'd0);
            check("halt_hold", 64'({addr, if_id}), 64'({9'd16, Bubble}));
        end
        cycle(1'b1, 1'b0, 9'd0);

        // Stall right after a halt keeps the halt visible
        cycle(1'b0, 1'b1, 9'd16);
        cycle(1'b0, 1'b0, 9'd0);
        cycle(1'b1, 1'b0, 9'd0);
        check("halt_stalled", 64'(if_id[0]), 64'd1);
        cycle(1'b0, 1'b0, 9'd0);

        // Speculative halt: flush out of HALTED
        cycle(1'b0, 1'b1, 9'd40);
        check("spec_halted", 64'(halted), 64'd0);
        check("spec_addr", 64'(addr), 64'd40);
        cycle(1'b0, 1'b0, 9'd0);
        check("spec_next", 64'(addr), 64'd44);

        // Randomized traffic
        for (int i = 0; i < 128; i++) begin
            r = $urandom;
            mem[i] = ($urandom_range(0, 9) == 0) ? {r[31:7], 7'h7F} : {r[31:7], 7'h13};
        end
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                  9'($urandom_range(0, 511)));
        end

        // Reset in the middle of a cycle
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        check("midrst_ifid", 64'(if_id), 64'(Bubble));
        @(negedge clk);
        reset = 1'b0;

        // Counter scenario: 5 fetches and 1 flush
        fill_addi();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 9'd0);
        cycle(1'b0, 1'b1, 9'd200);
`ifdef FETCH_PERF_CNT_EN
        check("cnt_fetch5", 64'(fetch_cnt), 64'd5);
        check("cnt_flush1", 64'(flush_cnt), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
